// File: rtl/cache_assoc_ctrl_if.sv
// cache_assoc_ctrl_if
// Bundles the CPU command/response handshake and the memory line bus of the
// set-associative cache controller, plus the hit/miss statistics.
//   slave  : the cache controller (takes CPU requests, drives memory commands)
//   master : the environment (issues CPU requests, serves memory beats)
// CPU side : cpu_valid/cpu_ready/cpu_cmd/cpu_addr/cpu_wdata -> cpu_resp_valid/cpu_rdata
// Mem side : mem_cmd/mem_addr/mem_wdata -> mem_rdata/mem_resp
// Stats    : hit_cnt, miss_cnt (saturating)
interface cache_assoc_ctrl_if #(
  parameter int ADDR_BITS     = 19,
  parameter int OFFSET_BITS   = 4,
  parameter int MEM_DATA_BITS = 16
);
  logic                             cpu_valid;
  logic                             cpu_ready;
  logic [2:0]                       cpu_cmd;
  logic [ADDR_BITS-1:0]             cpu_addr;
  logic [31:0]                      cpu_wdata;
  logic                             cpu_resp_valid;
  logic [31:0]                      cpu_rdata;
  logic [1:0]                       mem_cmd;
  logic [ADDR_BITS-OFFSET_BITS-1:0] mem_addr;
  logic [MEM_DATA_BITS-1:0]         mem_wdata;
  logic [MEM_DATA_BITS-1:0]         mem_rdata;
  logic                             mem_resp;
  logic [15:0]                      hit_cnt;
  logic [15:0]                      miss_cnt;

  modport master (
    output cpu_valid, cpu_cmd, cpu_addr, cpu_wdata, mem_rdata, mem_resp,
    input  cpu_ready, cpu_resp_valid, cpu_rdata, mem_cmd, mem_addr, mem_wdata,
           hit_cnt, miss_cnt
  );

  modport slave (
    input  cpu_valid, cpu_cmd, cpu_addr, cpu_wdata, mem_rdata, mem_resp,
    output cpu_ready, cpu_resp_valid, cpu_rdata, mem_cmd, mem_addr, mem_wdata,
           hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_assoc_ctrl.sv
// cache_assoc_ctrl
// N-way set-associative, write-back, write-allocate cache controller with
// true-LRU replacement, dirty-victim write-back, line invalidation and
// saturating hit/miss counters.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cache_assoc_ctrl_if.slave (CPU handshake, memory line bus, stats)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | ready for a CPU request
// S_LOOKUP | tag compare, hit handling, victim choice, counter update
// S_WB     | WRITE_LINE of the dirty victim (or invalidated line)
// S_GAP    | one idle memory cycle between write-back and refill
// S_REFILL | READ_LINE of the requested line into the chosen way
// S_RESP   | one-cycle completion pulse to the CPU
module cache_assoc_ctrl #(
  parameter int ADDR_BITS     = 19,
  parameter int SET_BITS      = 5,
  parameter int OFFSET_BITS   = 4,
  parameter int WAYS          = 2,
  parameter int MEM_DATA_BITS = 16
) (
  input logic              clk,
  input logic              rst_n,
  cache_assoc_ctrl_if.slave bus
);
  localparam int TAG_BITS   = ADDR_BITS - SET_BITS - OFFSET_BITS;
  localparam int SETS       = 1 << SET_BITS;
  localparam int LINE_BITS  = (1 << OFFSET_BITS) * 8;
  localparam int BEATS      = LINE_BITS / MEM_DATA_BITS;
  localparam int BEAT_BITS  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAY_BITS   = $clog2(WAYS);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_GAP, S_REFILL, S_RESP} state_t;
  state_t state, state_nxt;

  logic [2:0]           req_cmd;
  logic [ADDR_BITS-1:0] req_addr;
  logic [31:0]          req_wdata;
  logic [WAY_BITS-1:0]  way_q;
  logic [BEAT_BITS-1:0] beat;
  logic [31:0]          rdata_q;
  logic [15:0]          hit_cnt, miss_cnt;

  logic [LINE_BITS-1:0] data_mem  [SETS*WAYS];
  logic [TAG_BITS-1:0]  tag_mem   [SETS][WAYS];
  logic [WAYS-1:0]      valid_mem [SETS];
  logic [WAYS-1:0]      dirty_mem [SETS];
  logic [WAY_BITS-1:0]  age_mem   [SETS][WAYS];

  logic [OFFSET_BITS-1:0]        off;
  logic [SET_BITS-1:0]           set_idx;
  logic [TAG_BITS-1:0]           tag_idx;
  logic                          is_inval, is_write, accept, last_beat;
  logic                          hit, touch_en;
  logic [WAY_BITS-1:0]           hit_way, victim, way_sel;
  logic [SET_BITS+WAY_BITS-1:0]  line_idx;
  logic [LINE_BITS-1:0]          work_line, merged;
  logic [31:0]                   rd;

  assign off       = req_addr[OFFSET_BITS-1:0];
  assign set_idx   = req_addr[OFFSET_BITS +: SET_BITS];
  assign tag_idx   = req_addr[ADDR_BITS-1 -: TAG_BITS];
  assign is_inval  = (req_cmd == 3'd4);
  assign is_write  = req_cmd[2] && (req_cmd[1:0] != 2'd0);
  assign accept    = (state == S_IDLE) && bus.cpu_valid && (bus.cpu_cmd != 3'd0);
  assign last_beat = bus.mem_resp && (beat == BEAT_BITS'(BEATS - 1));
  assign way_sel   = (state == S_LOOKUP) ? hit_way : way_q;
  assign line_idx  = {set_idx, way_sel};
  assign touch_en  = (state == S_LOOKUP && !is_inval && hit) || (state == S_REFILL && last_beat);

  // Victim: maximum-age way, overridden by the lowest-index invalid way.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    victim  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_mem[set_idx][w] && tag_mem[set_idx][w] == tag_idx) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (age_mem[set_idx][w] == WAY_BITS'(WAYS - 1)) victim = WAY_BITS'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_mem[set_idx][w]) victim = WAY_BITS'(w);
    end
  end

  // During refill the incoming beat is folded in so the final beat can be
  // merged with write data and read back in the same cycle.
  always_comb begin
    int nb;
    int base;
    work_line = data_mem[line_idx];
    if (state == S_REFILL) work_line[beat*MEM_DATA_BITS +: MEM_DATA_BITS] = bus.mem_rdata;
    case (req_cmd[1:0])
      2'd1:    nb = 1;
      2'd2:    nb = 2;
      default: nb = 4;
    endcase
    base   = int'(off) & ~(nb - 1);
    merged = work_line;
    rd     = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < nb) begin
        rd[8*i +: 8] = work_line[8*(base+i) +: 8];
        if (is_write) merged[8*(base+i) +: 8] = req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_LOOKUP;
      S_LOOKUP: begin
        if (is_inval)  state_nxt = (hit && dirty_mem[set_idx][hit_way]) ? S_WB : S_RESP;
        else if (hit)  state_nxt = S_RESP;
        else if (valid_mem[set_idx][victim] && dirty_mem[set_idx][victim]) state_nxt = S_WB;
        else           state_nxt = S_REFILL;
      end
      S_WB:     if (last_beat) state_nxt = is_inval ? S_RESP : S_GAP;
      S_GAP:    state_nxt = S_REFILL;
      S_REFILL: if (last_beat) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_cmd   <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      way_q     <= '0;
      beat      <= '0;
      rdata_q   <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_mem[s][w] <= WAY_BITS'(w);
      end
    end else begin
      if ((state == S_WB || state == S_REFILL) && bus.mem_resp)
        beat <= last_beat ? '0 : beat + BEAT_BITS'(1);
      else if (state != S_WB && state != S_REFILL)
        beat <= '0;

      case (state)
        S_IDLE: if (accept) begin
          req_cmd   <= bus.cpu_cmd;
          req_addr  <= bus.cpu_addr;
          req_wdata <= bus.cpu_wdata;
        end
        S_LOOKUP: begin
          if (is_inval) begin
            rdata_q <= '0;
            way_q   <= hit_way;
            if (hit && !dirty_mem[set_idx][hit_way]) valid_mem[set_idx][hit_way] <= 1'b0;
          end else if (hit) begin
            if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            way_q   <= hit_way;
            rdata_q <= rd;
            if (is_write) dirty_mem[set_idx][hit_way] <= 1'b1;
          end else begin
            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            way_q <= victim;
          end
        end
        S_WB: if (last_beat && is_inval) begin
          valid_mem[set_idx][way_q] <= 1'b0;
          dirty_mem[set_idx][way_q] <= 1'b0;
        end
        S_REFILL: if (last_beat) begin
          valid_mem[set_idx][way_q] <= 1'b1;
          dirty_mem[set_idx][way_q] <= is_write;
          rdata_q                   <= rd;
        end
        default: ;
      endcase

      if (touch_en) begin
        for (int v = 0; v < WAYS; v++) begin
          if (v == int'(way_sel))
            age_mem[set_idx][v] <= '0;
          else if (age_mem[set_idx][v] < age_mem[set_idx][way_sel])
            age_mem[set_idx][v] <= age_mem[set_idx][v] + WAY_BITS'(1);
        end
      end
    end
  end

  // Line data and tags carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (state == S_LOOKUP && !is_inval && hit && is_write) data_mem[line_idx] <= merged;
    if (state == S_REFILL && bus.mem_resp) begin
      data_mem[line_idx] <= last_beat ? merged : work_line;
      if (last_beat) tag_mem[set_idx][way_q] <= tag_idx;
    end
  end

  assign bus.cpu_ready      = (state == S_IDLE);
  assign bus.cpu_resp_valid = (state == S_RESP);
  assign bus.cpu_rdata      = (state == S_RESP) ? rdata_q : '0;
  assign bus.mem_cmd        = (state == S_WB) ? 2'd3 : (state == S_REFILL) ? 2'd2 : 2'd0;
  assign bus.mem_addr       = (state == S_WB)     ? {tag_mem[set_idx][way_q], set_idx} :
                              (state == S_REFILL) ? {tag_idx, set_idx} : '0;
  assign bus.mem_wdata      = (state == S_WB) ? data_mem[line_idx][beat*MEM_DATA_BITS +: MEM_DATA_BITS] : '0;
  assign bus.hit_cnt        = hit_cnt;
  assign bus.miss_cnt       = miss_cnt;
endmodule

// File: tb/tb_cache_assoc_ctrl.sv
// tb_cache_assoc_ctrl
// Directed bench for cache_assoc_ctrl at default geometry (2 ways, 32 sets,
// 16-byte lines, 16-bit beats). Memory returns beat k = 0x0100+k on reads.
module tb_cache_assoc_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_assoc_ctrl_if #(.ADDR_BITS(19), .OFFSET_BITS(4), .MEM_DATA_BITS(16)) bus ();
  cache_assoc_ctrl #(.ADDR_BITS(19), .SET_BITS(5), .OFFSET_BITS(4), .WAYS(2), .MEM_DATA_BITS(16))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // Per-request observation record filled by do_req.
  logic [1:0]  b_cmd[$];
  logic [14:0] b_addr[$];
  int          b_beats[$];
  int          gaps[$];
  logic [15:0] wb_data[$];
  int          resp_cyc;
  int          last_end;
  logic [31:0] resp_data;
  bit          unstable;

  task automatic do_req(input logic [2:0] cmd, input logic [18:0] addr, input logic [31:0] wdata, input int gap);
    int cyc, inb, idx;
    logic [1:0] prev;
    bit done;
    b_cmd.delete(); b_addr.delete(); b_beats.delete(); gaps.delete(); wb_data.delete();
    unstable = 0; resp_cyc = -1; resp_data = '0; last_end = 0;
    @(negedge clk);
    bus.cpu_valid = 1'b1; bus.cpu_cmd = cmd; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    @(negedge clk);
    bus.cpu_valid = 1'b0; bus.cpu_cmd = 3'd0;
    cyc = 1; inb = 0; prev = 2'd0; done = 0;
    while (!done && cyc < 300) begin
      bus.mem_resp = 1'b0;
      if (bus.cpu_resp_valid) begin
        resp_cyc = cyc; resp_data = bus.cpu_rdata; done = 1;
      end else if (bus.mem_cmd != 2'd0) begin
        if (bus.mem_cmd != prev) begin
          b_cmd.push_back(bus.mem_cmd); b_addr.push_back(bus.mem_addr);
          b_beats.push_back(0); gaps.push_back(cyc - last_end - 1); inb = 0;
        end else if (bus.mem_addr != b_addr[b_addr.size()-1]) unstable = 1;
        if (inb % (gap + 1) == gap) begin
          idx = b_beats.size() - 1;
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = 16'h0100 + 16'(b_beats[idx]);
          if (bus.mem_cmd == 2'd3) wb_data.push_back(bus.mem_wdata);
          b_beats[idx] = b_beats[idx] + 1;
        end
        inb++; last_end = cyc;
      end
      prev = bus.mem_cmd;
      if (!done) begin @(negedge clk); cyc++; end
    end
    bus.mem_resp = 1'b0;
    if (!done) begin vectors++; miscompares++; $display("FAIL timeout cmd=%0d addr=%h: no cpu_resp_valid within 300 cycles", cmd, addr); end
  endtask

  task automatic test_reset();
    bus.cpu_valid = 0; bus.cpu_cmd = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.mem_rdata = 0; bus.mem_resp = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (bus.cpu_ready !== 1'b1) begin miscompares++; $display("FAIL reset cpu_ready got %b want 1", bus.cpu_ready); end
    vectors++; if (bus.cpu_resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset cpu_resp_valid got %b want 0", bus.cpu_resp_valid); end
    vectors++; if (bus.cpu_rdata !== 32'h0) begin miscompares++; $display("FAIL reset cpu_rdata got %h want 0", bus.cpu_rdata); end
    vectors++; if (bus.mem_cmd !== 2'd0) begin miscompares++; $display("FAIL reset mem_cmd got %0d want 0", bus.mem_cmd); end
    vectors++; if (bus.mem_addr !== 15'h0) begin miscompares++; $display("FAIL reset mem_addr got %h want 0", bus.mem_addr); end
    vectors++; if (bus.mem_wdata !== 16'h0) begin miscompares++; $display("FAIL reset mem_wdata got %h want 0", bus.mem_wdata); end
    vectors++; if (bus.hit_cnt !== 16'd0 || bus.miss_cnt !== 16'd0) begin miscompares++; $display("FAIL reset counters got %0d/%0d want 0/0", bus.hit_cnt, bus.miss_cnt); end
  endtask

  task automatic test_cold_miss();
    do_req(3'd3, 19'h00010, 32'h0, 0);
    vectors++; if (b_cmd.size() !== 1) begin miscompares++; $display("FAIL cold bursts got %0d want 1", b_cmd.size()); end
    vectors++; if (b_cmd[0] !== 2'd2) begin miscompares++; $display("FAIL cold mem_cmd got %0d want 2", b_cmd[0]); end
    vectors++; if (b_addr[0] !== 15'h001) begin miscompares++; $display("FAIL cold mem_addr got %h want 001", b_addr[0]); end
    vectors++; if (b_beats[0] !== 8) begin miscompares++; $display("FAIL cold beats got %0d want 8", b_beats[0]); end
    vectors++; if (unstable !== 1'b0) begin miscompares++; $display("FAIL cold mem_addr stability got %b want 0", unstable); end
    vectors++; if (resp_data !== 32'h01010100) begin miscompares++; $display("FAIL cold rdata got %h want 01010100", resp_data); end
    vectors++; if (resp_cyc !== last_end + 1) begin miscompares++; $display("FAIL cold resp latency got %0d want %0d", resp_cyc, last_end + 1); end
    vectors++; if (bus.miss_cnt !== 16'd1 || bus.hit_cnt !== 16'd0) begin miscompares++; $display("FAIL cold counters got %0d/%0d want 0/1", bus.hit_cnt, bus.miss_cnt); end
  endtask

  task automatic test_hit();
    do_req(3'd3, 19'h00010, 32'h0, 0);
    vectors++; if (resp_cyc !== 2) begin miscompares++; $display("FAIL hit latency got %0d want 2", resp_cyc); end
    vectors++; if (b_cmd.size() !== 0) begin miscompares++; $display("FAIL hit traffic got %0d bursts want 0", b_cmd.size()); end
    vectors++; if (resp_data !== 32'h01010100) begin miscompares++; $display("FAIL hit rdata got %h want 01010100", resp_data); end
    vectors++; if (bus.hit_cnt !== 16'd1) begin miscompares++; $display("FAIL hit hit_cnt got %0d want 1", bus.hit_cnt); end
    @(negedge clk);
    vectors++; if (bus.cpu_ready !== 1'b1 || bus.cpu_resp_valid !== 1'b0) begin miscompares++; $display("FAIL hit N+3 ready/resp got %b/%b want 1/0", bus.cpu_ready, bus.cpu_resp_valid); end
  endtask

  task automatic test_byte_merge();
    do_req(3'd5, 19'h00013, 32'h000000AB, 0);
    vectors++; if (b_cmd.size() !== 0 || resp_cyc !== 2) begin miscompares++; $display("FAIL merge write8 bursts/latency got %0d/%0d want 0/2", b_cmd.size(), resp_cyc); end
    do_req(3'd3, 19'h00010, 32'h0, 0);
    vectors++; if (resp_data !== 32'hAB010100) begin miscompares++; $display("FAIL merge read32 got %h want AB010100", resp_data); end
    vectors++; if (b_cmd.size() !== 0) begin miscompares++; $display("FAIL merge read32 traffic got %0d want 0", b_cmd.size()); end
    do_req(3'd2, 19'h00013, 32'h0, 0);
    vectors++; if (resp_data !== 32'h0000AB01) begin miscompares++; $display("FAIL merge read16 align got %h want 0000AB01", resp_data); end
    do_req(3'd7, 19'h00017, 32'hDEADBEEF, 0);
    do_req(3'd3, 19'h00014, 32'h0, 0);
    vectors++; if (resp_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL merge write32 align got %h want DEADBEEF", resp_data); end
    vectors++; if (bus.hit_cnt !== 16'd6 || bus.miss_cnt !== 16'd1) begin miscompares++; $display("FAIL merge counters got %0d/%0d want 6/1", bus.hit_cnt, bus.miss_cnt); end
  endtask

  task automatic test_lru_evict();
    do_req(3'd1, 19'h00000, 32'h0, 1);
    vectors++; if (b_addr[0] !== 15'h000 || resp_data !== 32'h0) begin miscompares++; $display("FAIL lru fill0 addr/rdata got %h/%h want 000/0", b_addr[0], resp_data); end
    do_req(3'd1, 19'h00200, 32'h0, 1);
    vectors++; if (b_addr[0] !== 15'h020) begin miscompares++; $display("FAIL lru fill1 addr got %h want 020", b_addr[0]); end
    do_req(3'd5, 19'h00000, 32'h0000005A, 1);
    do_req(3'd1, 19'h00200, 32'h0, 1);
    vectors++; if (b_cmd.size() !== 0) begin miscompares++; $display("FAIL lru rehit traffic got %0d want 0", b_cmd.size()); end
    do_req(3'd1, 19'h00400, 32'h0, 2);
    vectors++; if (b_cmd.size() !== 2) begin miscompares++; $display("FAIL evict bursts got %0d want 2", b_cmd.size()); end
    vectors++; if (b_cmd[0] !== 2'd3 || b_addr[0] !== 15'h000) begin miscompares++; $display("FAIL evict wb cmd/addr got %0d/%h want 3/000", b_cmd[0], b_addr[0]); end
    vectors++; if (wb_data[0] !== 16'h015A) begin miscompares++; $display("FAIL evict wb beat0 got %h want 015A", wb_data[0]); end
    vectors++; if (wb_data[7] !== 16'h0107 || b_beats[0] !== 8) begin miscompares++; $display("FAIL evict wb beat7/count got %h/%0d want 0107/8", wb_data[7], b_beats[0]); end
    vectors++; if (gaps[1] !== 1) begin miscompares++; $display("FAIL evict nop gap got %0d want 1", gaps[1]); end
    vectors++; if (b_cmd[1] !== 2'd2 || b_addr[1] !== 15'h040 || b_beats[1] !== 8) begin miscompares++; $display("FAIL evict refill cmd/addr/beats got %0d/%h/%0d want 2/040/8", b_cmd[1], b_addr[1], b_beats[1]); end
    vectors++; if (unstable !== 1'b0) begin miscompares++; $display("FAIL evict mem_addr stability got %b want 0", unstable); end
    do_req(3'd1, 19'h00200, 32'h0, 0);
    vectors++; if (b_cmd.size() !== 0) begin miscompares++; $display("FAIL lru survivor traffic got %0d want 0", b_cmd.size()); end
    do_req(3'd1, 19'h00000, 32'h0, 0);
    vectors++; if (b_cmd.size() !== 1 || b_cmd[0] !== 2'd2 || b_addr[0] !== 15'h000) begin miscompares++; $display("FAIL lru clean victim got %0d bursts cmd %0d addr %h want 1/2/000", b_cmd.size(), b_cmd[0], b_addr[0]); end
    vectors++; if (bus.hit_cnt !== 16'd9 || bus.miss_cnt !== 16'd5) begin miscompares++; $display("FAIL lru counters got %0d/%0d want 9/5", bus.hit_cnt, bus.miss_cnt); end
  endtask

  task automatic test_invalidate();
    do_req(3'd6, 19'h00021, 32'h0000BEEF, 0);
    do_req(3'd4, 19'h00020, 32'h0, 1);
    vectors++; if (b_cmd.size() !== 1 || b_cmd[0] !== 2'd3) begin miscompares++; $display("FAIL inval dirty bursts/cmd got %0d/%0d want 1/3", b_cmd.size(), b_cmd[0]); end
    vectors++; if (b_addr[0] !== 15'h002 || wb_data[0] !== 16'hBEEF || b_beats[0] !== 8) begin miscompares++; $display("FAIL inval wb addr/beat0/beats got %h/%h/%0d want 002/BEEF/8", b_addr[0], wb_data[0], b_beats[0]); end
    vectors++; if (resp_data !== 32'h0 || resp_cyc !== last_end + 1) begin miscompares++; $display("FAIL inval resp rdata/latency got %h/%0d want 0/%0d", resp_data, resp_cyc, last_end + 1); end
    do_req(3'd1, 19'h00020, 32'h0, 0);
    vectors++; if (b_cmd.size() !== 1 || b_cmd[0] !== 2'd2 || b_addr[0] !== 15'h002) begin miscompares++; $display("FAIL inval reread got %0d bursts cmd %0d addr %h want 1/2/002", b_cmd.size(), b_cmd[0], b_addr[0]); end
    do_req(3'd4, 19'h00020, 32'h0, 0);
    vectors++; if (b_cmd.size() !== 0 || resp_cyc !== 2) begin miscompares++; $display("FAIL inval clean bursts/latency got %0d/%0d want 0/2", b_cmd.size(), resp_cyc); end
    do_req(3'd1, 19'h00021, 32'h0, 0);
    vectors++; if (b_cmd.size() !== 1 || resp_data !== 32'h01) begin miscompares++; $display("FAIL inval clean reread bursts/rdata got %0d/%h want 1/01", b_cmd.size(), resp_data); end
    do_req(3'd4, 19'h01000, 32'h0, 0);
    vectors++; if (b_cmd.size() !== 0 || resp_cyc !== 2) begin miscompares++; $display("FAIL inval miss bursts/latency got %0d/%0d want 0/2", b_cmd.size(), resp_cyc); end
    vectors++; if (bus.hit_cnt !== 16'd9 || bus.miss_cnt !== 16'd8) begin miscompares++; $display("FAIL inval counters got %0d/%0d want 9/8", bus.hit_cnt, bus.miss_cnt); end
  endtask

  task automatic test_reset_mid_refill();
    int n, guard;
    @(negedge clk);
    bus.cpu_valid = 1'b1; bus.cpu_cmd = 3'd3; bus.cpu_addr = 19'h00030; bus.cpu_wdata = 32'h0;
    @(negedge clk);
    bus.cpu_valid = 1'b0; bus.cpu_cmd = 3'd0;
    n = 0; guard = 0;
    while (n < 3 && guard < 50) begin
      bus.mem_resp = 1'b0;
      if (bus.mem_cmd == 2'd2) begin bus.mem_resp = 1'b1; bus.mem_rdata = 16'h0100 + 16'(n); n++; end
      @(negedge clk); guard++;
    end
    bus.mem_resp = 1'b0;
    vectors++; if (n !== 3 || bus.mem_cmd !== 2'd2) begin miscompares++; $display("FAIL midrst refill beats/mem_cmd got %0d/%0d want 3/2", n, bus.mem_cmd); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus.mem_cmd !== 2'd0 || bus.mem_addr !== 15'h0) begin miscompares++; $display("FAIL midrst async mem_cmd/addr got %0d/%h want 0/0", bus.mem_cmd, bus.mem_addr); end
    vectors++; if (bus.cpu_ready !== 1'b1) begin miscompares++; $display("FAIL midrst cpu_ready got %b want 1", bus.cpu_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (bus.hit_cnt !== 16'd0 || bus.miss_cnt !== 16'd0) begin miscompares++; $display("FAIL midrst counters got %0d/%0d want 0/0", bus.hit_cnt, bus.miss_cnt); end
    do_req(3'd3, 19'h00030, 32'h0, 0);
    vectors++; if (b_cmd.size() !== 1 || b_beats[0] !== 8 || resp_data !== 32'h01010100) begin miscompares++; $display("FAIL midrst retry bursts/beats/rdata got %0d/%0d/%h want 1/8/01010100", b_cmd.size(), b_beats[0], resp_data); end
    do_req(3'd3, 19'h00010, 32'h0, 0);
    vectors++; if (b_cmd.size() !== 1 || bus.miss_cnt !== 16'd2) begin miscompares++; $display("FAIL midrst old line bursts/miss_cnt got %0d/%0d want 1/2", b_cmd.size(), bus.miss_cnt); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_byte_merge();
    test_lru_evict();
    test_invalidate();
    test_reset_mid_refill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
